// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: the pipeline shares one write port with a 2-deep multicycle result FIFO.
// Optional macro WB_ARB_PORT_EN adds an output-port register that is loaded by pipeline port writes.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_valid,
  input  logic [2:0]  p_rd,
  input  logic [15:0] p_data,
  input  logic        p_port_write,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [2:0]  m_rd,
  input  logic [15:0] m_data,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [15:0] out_port,
  output logic        stall_req,
  output logic        err_collision
);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_STALL  = 1'b1
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [2:0]  fifo_rd_q   [2];
  logic [15:0] fifo_data_q [2];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_d;
  logic [3:0]  starve_q, starve_d;
  logic        rf_we_q, rf_we_d;
  logic [2:0]  rf_waddr_q, rf_waddr_d;
  logic [15:0] rf_wdata_q, rf_wdata_d;
  logic        stall_req_q, stall_req_d;
  logic        err_q, err_d;
  logic        fifo_ne_s, push_s, pop_s, p_grant_s, port_wr_s;

`ifdef WB_ARB_PORT_EN
  logic [15:0] out_port_q, out_port_d;
  assign port_wr_s = p_port_write;
  assign out_port  = out_port_q;
`else
  logic unused_port_write_s;
  assign unused_port_write_s = p_port_write;
  assign port_wr_s = 1'b0;
  assign out_port  = 16'h0000;
`endif

  // The FIFO stops accepting only when full; reset forces it to refuse.
  assign m_ready       = rst_n && (count_q < 2'd2);
  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign stall_req     = stall_req_q;
  assign err_collision = err_q;

  // Grant selection, FIFO bookkeeping, starvation tracking and next output values.
  always_comb begin
    fifo_ne_s = (count_q != 2'd0);
    push_s    = m_valid && m_ready;
    // Grant decisions use the pre-push count, so a fresh entry waits one cycle.
    pop_s     = (state_q == ST_STALL) ? fifo_ne_s : (!p_valid && fifo_ne_s);
    p_grant_s = p_valid && (state_q == ST_NORMAL);

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    starve_d = starve_q;
    state_d  = state_q;
    if (pop_s) begin
      starve_d = 4'd0;
      state_d  = ST_NORMAL;
    end else if ((state_q == ST_NORMAL) && p_valid && fifo_ne_s) begin
      if (starve_q < LIMIT) begin
        starve_d = starve_q + 4'd1;
      end else begin
        starve_d = starve_q;
      end
      if (starve_d >= LIMIT) begin
        state_d = ST_STALL;
      end else begin
        state_d = ST_NORMAL;
      end
    end else begin
      starve_d = starve_q;
    end

    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pop_s) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = fifo_rd_q[rd_ptr_q];
      rf_wdata_d = fifo_data_q[rd_ptr_q];
    end else if (p_grant_s && !port_wr_s) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = p_rd;
      rf_wdata_d = p_data;
    end else begin
      rf_we_d = 1'b0;
    end

`ifdef WB_ARB_PORT_EN
    if (p_grant_s && port_wr_s) begin
      out_port_d = p_data;
    end else begin
      out_port_d = out_port_q;
    end
`endif

    stall_req_d = (state_d == ST_STALL);
    err_d       = err_q || ((state_q == ST_STALL) && p_valid);
  end

  // All state and registered outputs; reset discards queued results and any pending grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_NORMAL;
      fifo_rd_q[0]   <= 3'd0;
      fifo_rd_q[1]   <= 3'd0;
      fifo_data_q[0] <= 16'h0000;
      fifo_data_q[1] <= 16'h0000;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      starve_q       <= 4'd0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= 3'd0;
      rf_wdata_q     <= 16'h0000;
      stall_req_q    <= 1'b0;
      err_q          <= 1'b0;
`ifdef WB_ARB_PORT_EN
      out_port_q     <= 16'h0000;
`endif
    end else begin
      if (push_s) begin
        fifo_rd_q[wr_ptr_q]   <= m_rd;
        fifo_data_q[wr_ptr_q] <= m_data;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      state_q     <= state_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      stall_req_q <= stall_req_d;
      err_q       <= err_d;
`ifdef WB_ARB_PORT_EN
      out_port_q  <= out_port_d;
`endif
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a queue-based model predicts every output each cycle,
// plus literal expectations at the key points of each scenario.
module tb_wb_arbiter;

  localparam int LIMIT = 4;
`ifdef WB_ARB_PORT_EN
  localparam bit PORT_EN = 1'b1;
`else
  localparam bit PORT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, p_valid, p_port_write, m_valid;
  logic [2:0]  p_rd, m_rd;
  logic [15:0] p_data, m_data;
  logic        m_ready, rf_we, stall_req, err_collision;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata, out_port;

  int n_vec  = 0;
  int n_fail = 0;

  // Model state
  logic [18:0] mq[$];
  int          m_starve;
  bit          m_stall;
  logic        e_we, e_stall, e_err, e_ready;
  logic [2:0]  e_addr;
  logic [15:0] e_data, e_port;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data), .p_port_write(p_port_write),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .out_port(out_port),
    .stall_req(stall_req), .err_collision(err_collision)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp_v);
    end
  endtask

  // One clock edge of the arbiter, stated directly from the writeback rules.
  task automatic model_edge(input logic rst, input logic pv, input logic [2:0] prd,
                            input logic [15:0] pd, input logic ppw, input logic mv,
                            input logic [2:0] mrd, input logic [15:0] md);
    bit          had, take_m;
    logic [18:0] head;
    if (!rst) begin
      mq.delete();
      m_starve = 0; m_stall = 0;
      e_we = 1'b0; e_addr = 3'd0; e_data = 16'h0000; e_port = 16'h0000;
      e_stall = 1'b0; e_err = 1'b0;
    end else begin
      had    = (mq.size() > 0);
      take_m = had && (m_stall || !pv);
      if (m_stall && pv) e_err = 1'b1;
      e_we = 1'b0;
      if (take_m) begin
        head = mq.pop_front();
        e_we = 1'b1; e_addr = head[18:16]; e_data = head[15:0];
        m_starve = 0; m_stall = 0;
      end else begin
        if (pv) begin
          if (PORT_EN && ppw) e_port = pd;
          else begin e_we = 1'b1; e_addr = prd; e_data = pd; end
        end
        if (pv && had) begin
          if (m_starve < LIMIT) m_starve++;
          if (m_starve == LIMIT) m_stall = 1;
        end
      end
      e_stall = m_stall;
      if (mv && e_ready) mq.push_back({mrd, md});
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then compare all outputs after the rising edge.
  task automatic step(input logic rst, input logic pv, input logic [2:0] prd,
                      input logic [15:0] pd, input logic ppw, input logic mv,
                      input logic [2:0] mrd, input logic [15:0] md);
    rst_n = rst; p_valid = pv; p_rd = prd; p_data = pd; p_port_write = ppw;
    m_valid = mv; m_rd = mrd; m_data = md;
    e_ready = rst && (mq.size() < 2);
    #1;
    chk("m_ready", 16'(m_ready), 16'(e_ready));
    model_edge(rst, pv, prd, pd, ppw, mv, mrd, md);
    @(posedge clk);
    @(negedge clk);
    chk("rf_we", 16'(rf_we), 16'(e_we));
    chk("rf_waddr", 16'(rf_waddr), 16'(e_addr));
    chk("rf_wdata", rf_wdata, e_data);
    chk("out_port", out_port, e_port);
    chk("stall_req", 16'(stall_req), 16'(e_stall));
    chk("err_collision", 16'(err_collision), 16'(e_err));
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000);
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd0, 16'h0000);
    chk("lit_reset_we", 16'(rf_we), 16'h0000);
    chk("lit_reset_wdata", rf_wdata, 16'h0000);

    // Single multicycle result reaches the register file two cycles after push
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd3, 16'h1234);
    chk("lit_034_no_bypass", 16'(rf_we), 16'h0000);
    idle();
    chk("lit_034_we", 16'(rf_we), 16'h0001);
    chk("lit_034_addr", 16'(rf_waddr), 16'h0003);
    chk("lit_034_data", rf_wdata, 16'h1234);
    idle();
    chk("lit_034_hold", rf_wdata, 16'h1234);

    // FIFO fills while the pipeline keeps the port busy; third result waits for a pop
    step(1'b1, 1'b1, 3'd1, 16'h0101, 1'b0, 1'b1, 3'd1, 16'hA001);
    step(1'b1, 1'b1, 3'd1, 16'h0102, 1'b0, 1'b1, 3'd2, 16'hA002);
    chk("lit_035_full", 16'(m_ready), 16'h0000);
    step(1'b1, 1'b1, 3'd1, 16'h0103, 1'b0, 1'b1, 3'd4, 16'hA003);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd4, 16'hA003);
    chk("lit_035_popA", rf_wdata, 16'hA001);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd4, 16'hA003);
    chk("lit_035_popB", rf_wdata, 16'hA002);
    idle();
    chk("lit_035_popC", rf_wdata, 16'hA003);
    idle();

    // Starvation: stall after LIMIT blocked cycles, collision during stall
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd6, 16'h0606);
    for (int i = 0; i < LIMIT; i++) begin
      step(1'b1, 1'b1, 3'd5, 16'h5555, 1'b0, 1'b0, 3'd0, 16'h0000);
    end
    chk("lit_036_stall", 16'(stall_req), 16'h0001);
    chk("lit_036_blocked", 16'(rf_waddr), 16'h0005);
    step(1'b1, 1'b1, 3'd5, 16'h5AAA, 1'b0, 1'b0, 3'd0, 16'h0000);
    chk("lit_036_unstall", 16'(stall_req), 16'h0000);
    chk("lit_037_addr", 16'(rf_waddr), 16'h0006);
    chk("lit_037_data", rf_wdata, 16'h0606);
    chk("lit_037_err", 16'(err_collision), 16'h0001);
    idle();
    idle();
    chk("lit_037_sticky", 16'(err_collision), 16'h0001);

    // Output-port write
    step(1'b1, 1'b1, 3'd7, 16'hBEEF, 1'b1, 1'b0, 3'd0, 16'h0000);
`ifdef WB_ARB_PORT_EN
    chk("lit_038_port", out_port, 16'hBEEF);
    chk("lit_038_no_rf", 16'(rf_we), 16'h0000);
`else
    chk("lit_038_port", out_port, 16'h0000);
    chk("lit_038_rf_we", 16'(rf_we), 16'h0001);
    chk("lit_038_rf_data", rf_wdata, 16'hBEEF);
`endif

    // Same-register writes commit in grant order
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd2, 16'h1111);
    step(1'b1, 1'b1, 3'd2, 16'h2222, 1'b0, 1'b0, 3'd0, 16'h0000);
    chk("lit_028_first", rf_wdata, 16'h2222);
    idle();
    chk("lit_028_second", rf_wdata, 16'h1111);
    chk("lit_028_addr", 16'(rf_waddr), 16'h0002);

    // Mixed traffic
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'((i % 3) != 2), 3'(i), 16'(i * 257), 1'((i % 4) == 1),
           1'((i % 2) == 0), 3'(i + 3), 16'(16'hC000 + i));
    end

    // Reset with a full FIFO discards everything
    step(1'b1, 1'b1, 3'd1, 16'h0001, 1'b0, 1'b1, 3'd3, 16'h3333);
    step(1'b1, 1'b1, 3'd1, 16'h0002, 1'b0, 1'b1, 3'd4, 16'h4444);
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd0, 16'h0000);
    idle();
    chk("lit_039_ready", 16'(m_ready), 16'h0001);
    chk("lit_039_no_we", 16'(rf_we), 16'h0000);
    chk("lit_039_err_clr", 16'(err_collision), 16'h0000);
    idle();
    chk("lit_039_no_we2", 16'(rf_we), 16'h0000);
    idle();
    chk("lit_039_no_we3", 16'(rf_we), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the number of consecutive cycles the pipeline may block a pending multicycle result (range 1..15).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 p_valid  in  1  pipeline writeback request this cycle.
REQ-005 p_rd  in  3  pipeline destination register.
REQ-006 p_data  in  16  pipeline writeback data (already load/ALU selected).
REQ-007 p_port_write  in  1  pipeline write targets output port, not register file.
REQ-008 m_valid  in  1  multicycle unit result valid.
REQ-009 m_ready  out  1  arbiter accepts multicycle result.
REQ-010 m_rd  in  3  multicycle destination register.
REQ-011 m_data  in  16  multicycle result.
REQ-012 rf_we  out  1  register-file write enable, registered.
REQ-013 rf_waddr  out  3  register-file write address, registered.
REQ-014 rf_wdata  out  16  register-file write data, registered.
REQ-015 out_port  out  16  output port register.
REQ-016 stall_req  out  1  pipeline stall request, registered.
REQ-017 err_collision  out  1  sticky protocol-error flag.

Function
REQ-018 Multicycle results SHALL enter a 2-entry FIFO; push when m_valid && m_ready; m_ready = (count < 2).
REQ-019 A pushed entry SHALL NOT be eligible for grant in its push cycle (no bypass).
REQ-020 Push and pop in the same cycle SHALL leave count unchanged; FIFO order strictly preserved.
REQ-021 State NORMAL: p_valid wins the write port; else FIFO head (if non-empty) is granted and popped.
REQ-022 Granted write in cycle N SHALL appear on rf_we/rf_waddr/rf_wdata in cycle N+1 (latency 1); rf_we=0 when nothing granted, rf_waddr/rf_wdata hold last value.
REQ-023 Starve counter SHALL increment each NORMAL cycle with p_valid && FIFO non-empty, clear on any FIFO pop, saturating at STARVE_LIMIT.
REQ-024 When counter reaches STARVE_LIMIT, next state SHALL be STALL and stall_req=1 from that cycle.
REQ-025 State STALL: FIFO head granted regardless of p_valid; after that pop, counter clears, state returns to NORMAL, stall_req=0 next cycle.
REQ-026 p_valid=1 in STALL SHALL drop the pipeline write and set err_collision=1 until reset.
REQ-027 Pipeline grant with p_port_write=1 SHALL load out_port with p_data at N+1 and produce no rf write.
REQ-028 Same-register writes from both sources SHALL be committed in grant order; no merging.

Reset
REQ-029 While rst_n=0 at clk edge: FIFO empty, counter 0, state NORMAL, rf_we=0, rf_waddr=0, rf_wdata=0, out_port=0, stall_req=0, err_collision=0.
REQ-030 m_ready SHALL be 0 while rst_n=0 and 1 in first cycle after release.
REQ-031 Reset mid-operation SHALL discard FIFO contents and any pending grant without an rf write.

Configuration
REQ-032 Macro WB_ARB_PORT_EN defined: out_port register and REQ-027 behaviour present.
REQ-033 WB_ARB_PORT_EN undefined: out_port tied to 0, p_port_write ignored, pipeline grant always writes register file.

Verification
REQ-034 Reset then m_valid, m_rd=3, m_data=0x1234, p_valid=0 -> rf_we=1, rf_waddr=3, rf_wdata=0x1234 two cycles after push.
REQ-035 Push two results, hold m_valid -> m_ready=0 with count=2; third result accepted only after a pop.
REQ-036 p_valid=1 continuously, one FIFO entry, STARVE_LIMIT=4 -> stall_req=1 after 4 blocked cycles, FIFO entry written, stall_req=0 next.
REQ-037 p_valid=1 during STALL, p_rd=5 -> no rf write to 5, err_collision=1 and stays 1.
REQ-038 With WB_ARB_PORT_EN, p_port_write=1, p_data=0xBEEF -> out_port=0xBEEF next cycle, rf_we=0; without macro -> rf write of 0xBEEF, out_port=0.
REQ-039 Reset asserted with FIFO holding 2 entries -> no rf_we after release, m_ready=1, count=0.
